// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port plus the IF/ID register contents handed to decode.
interface if_fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  modport master (
    output imem_addr,
    input  imem_instr,
    output if_id_pc,
    output if_id_pc4,
    output if_id_instr,
    output if_id_valid
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  if_id_pc,
    input  if_id_pc4,
    input  if_id_instr,
    input  if_id_valid
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC register, next-PC selection (redirect > stall > +4) and the IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating fetch/bubble performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  if_fetch_stage_if.master     fb,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 misalign_err
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_bubble_cnt
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        load_bubble;
  logic        load_fetch;

  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;

  assign pc_plus4    = pc + 32'd4;
  assign load_bubble = flush | redirect_valid;
  assign load_fetch  = ~load_bubble & ~stall;

  always_comb begin
    pc_next = pc_plus4;
    if (redirect_valid) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      pc           <= pc_next;
      misalign_err <= redirect_valid & (|redirect_pc[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc    <= '0;
      ifid_pc4   <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (load_bubble) begin
      ifid_pc    <= '0;
      ifid_pc4   <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (load_fetch) begin
      ifid_pc    <= pc;
      ifid_pc4   <= pc_plus4;
      ifid_instr <= fb.imem_instr;
      ifid_valid <= 1'b1;
    end
  end

  assign fb.imem_addr   = pc;
  assign fb.if_id_pc    = ifid_pc;
  assign fb.if_id_pc4   = ifid_pc4;
  assign fb.if_id_instr = ifid_instr;
  assign fb.if_id_valid = ifid_valid;

`ifdef IF_PERF_CNT_EN
  // Every edge counts as exactly one of: real fetch, or bubble/stall-hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else if (load_fetch) begin
      if (perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
    end else begin
      if (perf_bubble_cnt != '1) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, stall, jump, misaligned redirect, wrap and async reset.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err, misalign_err_w;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [0:63];

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
  logic [31:0] perf_fetch_cnt_w, perf_bubble_cnt_w;
`endif

  if_fetch_stage_if fb ();
  if_fetch_stage_if fbw ();

  always #5 clk = ~clk;

  assign fb.imem_instr  = mem[fb.imem_addr[7:2]];
  assign fbw.imem_instr = 32'h1234_5678;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fb(fb),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .misalign_err(misalign_err)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .fb(fbw),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .misalign_err(misalign_err_w)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt_w), .perf_bubble_cnt(perf_bubble_cnt_w)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid, input logic [31:0] addr);
    chk({tag, "_pc"},    fb.if_id_pc, pc);
    chk({tag, "_instr"}, fb.if_id_instr, instr);
    chk({tag, "_valid"}, {31'd0, fb.if_id_valid}, {31'd0, valid});
    chk({tag, "_addr"},  fb.imem_addr, addr);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    mem[0]  = 32'h2008_0005;
    mem[1]  = 32'h2009_000A;
    mem[2]  = 32'h0109_5020;
    mem[3]  = 32'hAAAA_0003;
    mem[4]  = 32'h8C0B_0000;
    mem[5]  = 32'h0168_6020;
    mem[9]  = 32'h1111_0024;
    mem[11] = 32'h2222_002C;
    mem[12] = 32'h200F_0007;

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0, 32'h0);
    chk("rst_pc4", fb.if_id_pc4, 32'h0);
    chk("rst_mis", {31'd0, misalign_err}, 32'h0);
    chk("rstw_addr", fbw.imem_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    step();
    chk_ifid("e1", 32'h0, 32'h2008_0005, 1'b1, 32'h4);
    chk("wrap_pc", fbw.if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", fbw.if_id_pc4, 32'h0);
    chk("wrap_addr", fbw.imem_addr, 32'h0);
    step();
    chk_ifid("e2", 32'h4, 32'h2009_000A, 1'b1, 32'h8);
    step();
    chk_ifid("e3", 32'h8, 32'h0109_5020, 1'b1, 32'hC);
    chk("e3_pc4", fb.if_id_pc4, 32'hC);
    step();
    step();
    chk_ifid("e5", 32'h10, 32'h8C0B_0000, 1'b1, 32'h14);

    stall = 1'b1;
    step();
    chk_ifid("stall", 32'h10, 32'h8C0B_0000, 1'b1, 32'h14);
    chk("stall_pc4", fb.if_id_pc4, 32'h14);
    stall = 1'b0;
    step();
    chk_ifid("post_stall", 32'h14, 32'h0168_6020, 1'b1, 32'h18);

    redirect_valid = 1'b1; redirect_pc = 32'h30;
    step();
    chk_ifid("jmp", 32'h0, 32'h0, 1'b0, 32'h30);
    chk("jmp_mis", {31'd0, misalign_err}, 32'h0);
    redirect_valid = 1'b0;
    step();
    chk_ifid("jmp_tgt", 32'h30, 32'h200F_0007, 1'b1, 32'h34);
    chk("jmp_pc4", fb.if_id_pc4, 32'h34);

    redirect_valid = 1'b1; redirect_pc = 32'h26; stall = 1'b1; flush = 1'b1;
    step();
    chk_ifid("mis", 32'h0, 32'h0, 1'b0, 32'h24);
    chk("mis_err", {31'd0, misalign_err}, 32'h1);
    redirect_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    step();
    chk("mis_err_clr", {31'd0, misalign_err}, 32'h0);
    chk_ifid("mis_tgt", 32'h24, 32'h1111_0024, 1'b1, 32'h28);

    flush = 1'b1;
    step();
    chk_ifid("flush", 32'h0, 32'h0, 1'b0, 32'h2C);
    stall = 1'b1;
    step();
    chk_ifid("flush_stall", 32'h0, 32'h0, 1'b0, 32'h2C);
    flush = 1'b0; stall = 1'b0;
    step();
    chk_ifid("post_flush", 32'h2C, 32'h2222_002C, 1'b1, 32'h30);

    // Assert reset between edges; outputs must clear without a clock.
    #2 rst_n = 1'b0;
    #1;
    chk_ifid("arst", 32'h0, 32'h0, 1'b0, 32'h0);
    chk("arst_pc4", fb.if_id_pc4, 32'h0);
    chk("arstw_addr", fbw.imem_addr, 32'hFFFF_FFFC);
`ifdef IF_PERF_CNT_EN
    chk("arst_fcnt", perf_fetch_cnt, 32'h0);
    chk("arst_bcnt", perf_bubble_cnt, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    chk_ifid("run5", 32'h10, 32'h8C0B_0000, 1'b1, 32'h14);
    stall = 1'b1;
    step();
    stall = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h30;
    step();
    redirect_valid = 1'b0;
    chk("perf_addr", fb.imem_addr, 32'h30);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, 32'd5);
    chk("perf_bubble", perf_bubble_cnt, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register and drives the combinational instruction memory address, then captures the returned word into the IF/ID pipeline register.
- Accepts load-use stall and flush from the hazard unit, plus branch/jump/jr redirects resolved downstream.
- Output feeds the ID (decode) stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- imem_addr  out  32  byte address to instruction memory; equals the PC register.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- flush  in  1  hazard unit: squash IF/ID (load bubble).
- redirect_valid  in  1  branch taken / j / jal / jr target valid this cycle.
- redirect_pc  in  32  redirect target byte address.
- if_id_pc  out  32  PC of the instruction held in IF/ID.
- if_id_pc4  out  32  if_id_pc + 4 (jal link value).
- if_id_instr  out  32  instruction held in IF/ID.
- if_id_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- misalign_err  out  1  one-cycle pulse: redirect target had nonzero [1:0].

Behaviour:
- Reset (rst_n=0, takes effect immediately, mid-operation included): pc=RESET_PC; if_id_valid=0; if_id_instr=NOP_INSTR; if_id_pc=0; if_id_pc4=0; misalign_err=0.
- imem_addr is driven directly from the pc register, with no combinational path from inputs.
- Next-PC priority, per edge:
  - redirect_valid: pc <= {redirect_pc[31:2],2'b00}.
  - else stall: pc holds.
  - else: pc <= pc+4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- IF/ID priority, per edge:
  - flush or redirect_valid: load bubble (valid=0, instr=NOP_INSTR, pc=0, pc4=0).
  - else stall: hold all IF/ID fields.
  - else: instr<=imem_instr, pc<=pc, pc4<=pc+4 (wrapping), valid<=1.
- Redirect always overrides stall.
- Flush always overrides stall.
- flush without redirect_valid still advances or holds the PC per the next-PC rules.
- Latency: the word at address A appears in IF/ID one edge after the edge at which pc becomes A. The first valid instruction appears on the first edge after rst_n deasserts.
- Redirect penalty: one bubble. The target instruction reaches IF/ID two edges after redirect_valid is sampled.
- misalign_err <= redirect_valid & |redirect_pc[1:0]. It is high for exactly one cycle per offending redirect; the PC is still loaded with the aligned address.
- Inputs are sampled only at clock edges; no handshake beyond stall. Multi-cycle stall holds state indefinitely.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt (32) and perf_bubble_cnt (32), both reset to 0 asynchronously.
  - perf_fetch_cnt increments on each edge where IF/ID loads with valid=1.
  - perf_bubble_cnt increments on each edge where IF/ID loads a bubble or holds due to stall.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then run, memory holding 0x20080005, 0x2009000A, 0x01095020 at 0x0/0x4/0x8 -> edge1: if_id_pc=0, instr=0x20080005, valid=1. Edge3: if_id_pc=8, instr=0x01095020, pc4=0xC, imem_addr=0xC.
- Load-use stall: IF/ID holds pc=0x10 instr=0x8C0B0000, stall=1 for one edge -> IF/ID unchanged and imem_addr stays 0x14. Next edge: if_id_pc=0x14, instr=0x01686020.
- Jump: redirect_valid=1, redirect_pc=0x30 -> next edge imem_addr=0x30, if_id_valid=0. Following edge: if_id_pc=0x30, instr=0x200F0007.
- Redirect with stall=1 and flush=1 same cycle -> imem_addr=redirect target, IF/ID bubble. Misaligned target 0x26 -> imem_addr=0x24, misalign_err=1 for one cycle.
- RESET_PC=0xFFFFFFFC -> edge1: if_id_pc4=0x0, imem_addr=0x0.
- Async reset mid-run -> outputs return to reset values before the next edge. With IF_PERF_CNT_EN defined, 5 valid fetches + 1 stall + 1 redirect gives fetch_cnt=5, bubble_cnt=2.
